// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST march controller.
// Each element is described by direction, op count, op order and its read/write backgrounds.
package mbist_pkg;

    localparam int ELEM_W = 3;
    localparam logic [ELEM_W-1:0] LAST_ELEM = 3'd5;
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Op encoding matches the write_read pin polarity.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef struct packed {
        logic       down;
        logic [1:0] n_ops;
        op_t        op0;
        op_t        op1;
        logic       rd_bit;
        logic       wr_bit;
    } elem_cfg_t;

    localparam elem_cfg_t ELEM_M0 = '{down: 1'b0, n_ops: 2'd1, op0: OP_WRITE, op1: OP_WRITE, rd_bit: 1'b0, wr_bit: 1'b0};
    localparam elem_cfg_t ELEM_M1 = '{down: 1'b0, n_ops: 2'd2, op0: OP_READ,  op1: OP_WRITE, rd_bit: 1'b0, wr_bit: 1'b1};
    localparam elem_cfg_t ELEM_M2 = '{down: 1'b0, n_ops: 2'd2, op0: OP_READ,  op1: OP_WRITE, rd_bit: 1'b1, wr_bit: 1'b0};
    localparam elem_cfg_t ELEM_M3 = '{down: 1'b1, n_ops: 2'd2, op0: OP_READ,  op1: OP_WRITE, rd_bit: 1'b0, wr_bit: 1'b1};
    localparam elem_cfg_t ELEM_M4 = '{down: 1'b1, n_ops: 2'd2, op0: OP_READ,  op1: OP_WRITE, rd_bit: 1'b1, wr_bit: 1'b0};
    localparam elem_cfg_t ELEM_M5 = '{down: 1'b0, n_ops: 2'd1, op0: OP_READ,  op1: OP_READ,  rd_bit: 1'b0, wr_bit: 1'b0};

    function automatic elem_cfg_t elem_cfg(input logic [ELEM_W-1:0] e);
        case (e)
            3'd0:    return ELEM_M0;
            3'd1:    return ELEM_M1;
            3'd2:    return ELEM_M2;
            3'd3:    return ELEM_M3;
            3'd4:    return ELEM_M4;
            default: return ELEM_M5;
        endcase
    endfunction

endpackage

// File: rtl/mbist_rdata_cmp.sv
// Two-stage expect pipeline aligned to the memory's read latency, plus the
// comparator, first-failure capture and saturating mismatch counter.
module mbist_rdata_cmp
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ELEM_W-1:0]     rd_elem,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ELEM_W-1:0]     fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [7:0]            fail_count
);

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] exp;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ELEM_W-1:0]     elem;
    } stage_t;

    stage_t s1, s2;
    logic   mismatch;

    assign mismatch = s2.vld && (rdata != s2.exp);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= '{vld: rd_issue, exp: exp_data, addr: rd_addr, elem: rd_elem};
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_data  <= '0;
            fail_count <= '0;
        end else if (mismatch) begin
            fail <= 1'b1;
            if (fail_count != 8'hFF) begin
                fail_count <= fail_count + 8'd1;
            end
            // Only the first mismatch of a run is kept for diagnosis.
            if (!fail) begin
                fail_addr <= s2.addr;
                fail_elem <= s2.elem;
                fail_data <= rdata;
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- initiator: sequences elements M0..M5 over addresses 0..CAPACITY and
// drives the single-port memory; read checking is delegated to mbist_rdata_cmp.
//   state | meaning
//   IDLE  | waiting for start after reset
//   SETUP | one cycle per element, first address and background presented
//   RUN   | one memory op per cycle
//   DRAIN | two cycles flushing the read pipeline
//   DONE  | result valid, waiting for start
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ELEM_W-1:0]     fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [7:0]            fail_count,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = ADDR_WIDTH'(CAPACITY);
    localparam logic                  DRAIN_LOAD = 1'(DRAIN_CYCLES - 1);

    state_t                state, state_nxt;
    logic [ELEM_W-1:0]     elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  op_sel;
    logic                  drain_cnt;

    elem_cfg_t             cfg;
    op_t                   cur_op;
    logic [ADDR_WIDTH-1:0] first_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  op_last;
    logic                  addr_last;
    logic                  elem_end;
    logic                  start_ok;
    logic                  rd_issue;
    logic [DATA_WIDTH-1:0] exp_data;

    assign cfg        = elem_cfg(elem);
    assign cur_op     = op_sel ? cfg.op1 : cfg.op0;
    assign first_addr = cfg.down ? ADDR_MAX : '0;
    assign last_addr  = cfg.down ? '0 : ADDR_MAX;
    assign op_last    = (({1'b0, op_sel} + 2'd1) == cfg.n_ops);
    assign addr_last  = (addr == last_addr);
    assign elem_end   = (state == RUN) && op_last && addr_last;
    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign exp_data   = {DATA_WIDTH{cfg.rd_bit}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SETUP;
            SETUP:      state_nxt = RUN;
            RUN:        if (elem_end) state_nxt = (elem == LAST_ELEM) ? DRAIN : SETUP;
            DRAIN:      if (drain_cnt == 1'b0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Address steps only after the last op at an address and never wraps past a bound.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem      <= '0;
            addr      <= '0;
            op_sel    <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        elem   <= '0;
                        op_sel <= 1'b0;
                    end
                end
                SETUP: begin
                    addr   <= first_addr;
                    op_sel <= 1'b0;
                end
                RUN: begin
                    if (!op_last) begin
                        op_sel <= 1'b1;
                    end else begin
                        op_sel <= 1'b0;
                        if (!addr_last) begin
                            addr <= cfg.down ? addr - 1'b1 : addr + 1'b1;
                        end else if (elem == LAST_ELEM) begin
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            elem <= elem + 1'b1;
                        end
                    end
                end
                DRAIN: drain_cnt <= drain_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        write_read = 1'b0;
        address    = '0;
        wdata      = '0;
        rd_issue   = 1'b0;
        case (state)
            SETUP: begin
                busy    = 1'b1;
                address = first_addr;
                wdata   = {DATA_WIDTH{cfg.wr_bit}};
            end
            RUN: begin
                busy       = 1'b1;
                address    = addr;
                wdata      = {DATA_WIDTH{cfg.wr_bit}};
                write_read = (cur_op == OP_WRITE);
                rd_issue   = (cur_op == OP_READ);
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    mbist_rdata_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .rd_issue  (rd_issue),
        .exp_data  (exp_data),
        .rd_addr   (addr),
        .rd_elem   (elem),
        .rdata     (rdata),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_data (fail_data),
        .fail_count(fail_count)
    );

endmodule
